mod_exp_ctrl: RTL and testbench

Initiator-side controller that computes result = base^exp mod modulus by left-to-right square-and-multiply. It forms 2*BIT-bit products internally and sends each product to the shift/subtract reducer over that block's start/busy handshake. It sits above the reducer as the RSA encrypt/decrypt engine, and also owns the reducer's start line and operand inputs.

---
 rtl/mod_exp_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_mod_exp_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mod_exp_ctrl.sv
// Modular exponentiation controller: left-to-right square-and-multiply,
// each 2*BIT-bit product is handed to an external shift/subtract reducer.
module mod_exp_ctrl #(
  parameter int BIT     = 8,
  parameter int HSK_TMO = 4,
  parameter int OP_TMO  = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [BIT-1:0] base,
  input  logic [BIT-1:0] exp,
  input  logic [BIT-1:0] modulus,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [BIT-1:0] result,
  output logic           red_start,
  input  logic           red_busy,
  output logic [BIT:0]   red_hreg,
  output logic [BIT-1:0] red_lreg,
  output logic [BIT-1:0] red_c,
  input  logic [BIT-1:0] red_m
);

  localparam int IW   = (BIT > 1) ? $clog2(BIT) : 1;
  localparam int TMAX = (HSK_TMO > OP_TMO) ? HSK_TMO : OP_TMO;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_HI, S_WAIT_LO, S_RELEASE, S_FIN
  } state_e;

  typedef enum logic [1:0] {OP_REDB, OP_SQR, OP_MUL} op_e;

  state_e         state_q, state_d;
  op_e            op_q, op_d;
  logic [IW-1:0]  i_q, i_d;
  logic [TW-1:0]  cnt_q, cnt_d;
  logic [BIT-1:0] base_q, base_d, exp_q, exp_d, mod_q, mod_d;
  logic [BIT-1:0] acc_q, acc_d, bm_q, bm_d, result_q, result_d;
  logic           busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic           red_start_q, red_start_d;
  logic [BIT:0]   red_hreg_q, red_hreg_d;
  logic [BIT-1:0] red_lreg_q, red_lreg_d, red_c_q, red_c_d;

  // Successor of the operation that just completed
  op_e            nxt_op;
  logic [IW-1:0]  nxt_i;
  logic           nxt_fin;

  always_comb begin
    nxt_op  = OP_SQR;
    nxt_i   = i_q;
    nxt_fin = 1'b0;
    case (op_q)
      OP_REDB: nxt_op = OP_SQR;
      OP_SQR: begin
        if (exp_q[i_q])      nxt_op  = OP_MUL;
        else if (i_q == '0)  nxt_fin = 1'b1;
        else                 nxt_i   = i_q - IW'(1);
      end
      default: begin
        if (i_q == '0) nxt_fin = 1'b1;
        else           nxt_i   = i_q - IW'(1);
      end
    endcase
  end

  // Operands for the op being launched; RELEASE launches the successor directly
  op_e            issue_op;
  logic [BIT-1:0] mul_b;
  logic [2*BIT-1:0] a_ext, b_ext, prod;
  logic [BIT:0]   opnd_h;
  logic [BIT-1:0] opnd_l;

  always_comb begin
    issue_op = (state_q == S_RELEASE) ? nxt_op : op_q;
    mul_b    = (issue_op == OP_MUL) ? bm_q : acc_q;
    a_ext    = {{BIT{1'b0}}, acc_q};
    b_ext    = {{BIT{1'b0}}, mul_b};
    prod     = a_ext * b_ext;
    if (issue_op == OP_REDB) begin
      opnd_h = '0;
      opnd_l = base_q;
    end else begin
      opnd_h = {1'b0, prod[2*BIT-1:BIT]};
      opnd_l = prod[BIT-1:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    i_d         = i_q;
    cnt_d       = cnt_q;
    base_d      = base_q;
    exp_d       = exp_q;
    mod_d       = mod_q;
    acc_d       = acc_q;
    bm_d        = bm_q;
    result_d    = result_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    red_start_d = red_start_q;
    red_hreg_d  = red_hreg_q;
    red_lreg_d  = red_lreg_q;
    red_c_d     = red_c_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = base;
          exp_d   = exp;
          mod_d   = modulus;
          acc_d   = BIT'(1);
          i_d     = IW'(BIT - 1);
          err_d   = 1'b0;
          busy_d  = 1'b1;
          op_d    = OP_REDB;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        red_hreg_d  = opnd_h;
        red_lreg_d  = opnd_l;
        red_c_d     = mod_q;
        red_start_d = 1'b1;
        cnt_d       = '0;
        state_d     = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (red_busy) begin
          cnt_d   = '0;
          state_d = S_WAIT_LO;
        end else if (cnt_q == TW'(HSK_TMO - 1)) begin
          err_d       = 1'b1;
          red_start_d = 1'b0;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      S_WAIT_LO: begin
        if (!red_busy) begin
          if (op_q == OP_REDB) bm_d  = red_m;
          else                 acc_d = red_m;
          red_start_d = 1'b0;
          state_d     = S_RELEASE;
        end else if (cnt_q == TW'(OP_TMO - 1)) begin
          err_d       = 1'b1;
          red_start_d = 1'b0;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      S_RELEASE: begin
        // red_start is low for this single cycle, then the next op is issued
        if (nxt_fin) begin
          state_d = S_FIN;
        end else begin
          op_d        = nxt_op;
          i_d         = nxt_i;
          red_hreg_d  = opnd_h;
          red_lreg_d  = opnd_l;
          red_c_d     = mod_q;
          red_start_d = 1'b1;
          cnt_d       = '0;
          state_d     = S_WAIT_HI;
        end
      end
      S_FIN: begin
        result_d = acc_q;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_REDB;
      i_q         <= '0;
      cnt_q       <= '0;
      base_q      <= '0;
      exp_q       <= '0;
      mod_q       <= '0;
      acc_q       <= '0;
      bm_q        <= '0;
      result_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      red_start_q <= 1'b0;
      red_hreg_q  <= '0;
      red_lreg_q  <= '0;
      red_c_q     <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      i_q         <= i_d;
      cnt_q       <= cnt_d;
      base_q      <= base_d;
      exp_q       <= exp_d;
      mod_q       <= mod_d;
      acc_q       <= acc_d;
      bm_q        <= bm_d;
      result_q    <= result_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      red_start_q <= red_start_d;
      red_hreg_q  <= red_hreg_d;
      red_lreg_q  <= red_lreg_d;
      red_c_q     <= red_c_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign result    = result_q;
  assign red_start = red_start_q;
  assign red_hreg  = red_hreg_q;
  assign red_lreg  = red_lreg_q;
  assign red_c     = red_c_q;

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Bench for mod_exp_ctrl: behavioural reducer with selectable faults,
// scoreboard of expected {result, err} popped on every done pulse.
module tb_mod_exp_ctrl;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [7:0] base, exp, modulus;
  logic       busy, done, err;
  logic [7:0] result;
  logic       red_start, red_busy;
  logic [8:0] red_hreg;
  logic [7:0] red_lreg, red_c, red_m;

  always #5 clk = ~clk;

  mod_exp_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .exp(exp),
    .modulus(modulus), .busy(busy), .done(done), .err(err), .result(result),
    .red_start(red_start), .red_busy(red_busy), .red_hreg(red_hreg),
    .red_lreg(red_lreg), .red_c(red_c), .red_m(red_m)
  );

  // Reducer model: mode 0 = working, 1 = busy never rises, 2 = busy never falls
  int          mode = 0;
  logic        rbusy, rdone;
  logic [2:0]  rcnt;
  logic [16:0] num, rem;
  logic [7:0]  rm;
  assign red_busy = rbusy;
  assign red_m    = rm;

  always @(posedge clk) begin
    if (rst) begin
      rbusy <= 1'b0; rdone <= 1'b0; rcnt <= '0; num <= '0; rm <= '0;
    end else if (mode == 1) begin
      rbusy <= 1'b0;
    end else if (mode == 2) begin
      if (red_start) rbusy <= 1'b1;
    end else begin
      if (!red_start) begin
        rbusy <= 1'b0; rdone <= 1'b0;
      end else if (!rbusy && !rdone) begin
        rbusy <= 1'b1;
        rcnt  <= 3'($urandom_range(0, 5));
        num   <= {red_hreg, red_lreg};
      end else if (rbusy) begin
        if (rcnt == 0) begin
          rem   = num % {9'd0, red_c};
          rm    <= rem[7:0];
          rbusy <= 1'b0;
          rdone <= 1'b1;
        end else begin
          rcnt <= rcnt - 3'd1;
        end
      end
    end
  end

  int   rise_cnt = 0, done_cnt = 0;
  logic rs_prev = 1'b0;
  always @(negedge clk) begin
    rs_prev <= red_start;
    if (red_start && !rs_prev) rise_cnt <= rise_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  typedef struct packed { logic [7:0] res; logic err; } exp_t;
  exp_t sb[$];
  int   errors = 0, checks = 0;
  logic [7:0] last_res = 8'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // Independent reference: right-to-left binary exponentiation
  function automatic logic [7:0] ref_modexp(input logic [7:0] b, input logic [7:0] e,
                                            input logic [7:0] m);
    int unsigned r, x;
    r = 1 % m;
    x = b % m;
    for (int k = 0; k < 8; k++) begin
      if (e[k]) r = (r * x) % m;
      x = (x * x) % m;
    end
    return r[7:0];
  endfunction

  task automatic launch(input logic [7:0] b, input logic [7:0] e, input logic [7:0] m,
                        input logic expect_err);
    exp_t x;
    @(negedge clk);
    start = 1'b1; base = b; exp = e; modulus = m;
    if (expect_err) x = '{res: last_res, err: 1'b1};
    else begin
      last_res = ref_modexp(b, e, m);
      x = '{res: last_res, err: 1'b0};
    end
    sb.push_back(x);
    @(negedge clk);
    start = 1'b0;
    $display("launch base=%0d exp=%0d mod=%0d busy=%0b err=%0b", b, e, m, busy, err);
  endtask

  task automatic wait_done(input string tag);
    int   n;
    exp_t x;
    n = 0;
    while (!done && n < 3000) begin @(negedge clk); n++; end
    check({tag, "_done"}, 32'(done), 32'd1);
    if (done && sb.size() > 0) begin
      x = sb.pop_front();
      check({tag, "_result"}, 32'(result), 32'(x.res));
      check({tag, "_err"}, 32'(err), 32'(x.err));
      $display("done %s result=%0d err=%0b (want %0d/%0b)", tag, result, err, x.res, x.err);
    end
    @(negedge clk);
  endtask

  initial begin
    int n, d, r0, dc0;
    rst = 1'b1; start = 1'b0; base = '0; exp = '0; modulus = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_result", 32'(result), 0);
    check("rst_red_start", 32'(red_start), 0);
    check("rst_hreg", 32'(red_hreg), 0);
    check("rst_lreg", 32'(red_lreg), 0);
    check("rst_c", 32'(red_c), 0);
    rst = 1'b0;

    r0 = rise_cnt;
    launch(8'd3, 8'd5, 8'd7, 1'b0);
    check("busy_after_start", 32'(busy), 1);
    wait_done("3p5m7");
    check("3p5m7_ops", 32'(rise_cnt - r0), 32'd11);

    launch(8'd200, 8'd3, 8'd251, 1'b0); wait_done("200p3m251");
    launch(8'd10, 8'd1, 8'd7, 1'b0);    wait_done("10p1m7");
    launch(8'd4, 8'd0, 8'd7, 1'b0);     wait_done("exp0");
    launch(8'd5, 8'd9, 8'd1, 1'b0);     wait_done("mod1");
    launch(8'd3, 8'd5, 8'd7, 1'b0);     wait_done("3p5m7_b");

    // Reset during the third reducer operation
    r0 = rise_cnt;
    launch(8'd3, 8'd5, 8'd7, 1'b0);
    n = 0;
    while (rise_cnt - r0 < 3 && n < 500) begin @(negedge clk); n++; end
    check("third_op_seen", 32'(rise_cnt - r0), 32'd3);
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    last_res = 8'd0;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_red_start", 32'(red_start), 0);
    check("midrst_result", 32'(result), 0);
    launch(8'd3, 8'd5, 8'd7, 1'b0); wait_done("after_rst");

    // Start while busy is ignored
    dc0 = done_cnt;
    launch(8'd3, 8'd5, 8'd7, 1'b0);
    repeat (8) @(negedge clk);
    start = 1'b1; base = 8'd200; exp = 8'd3; modulus = 8'd251;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignored_start");
    repeat (40) @(negedge clk);
    check("ignored_start_dones", 32'(done_cnt - dc0), 32'd1);

    // Reducer never raises busy: done 4 cycles after red_start rises
    mode = 1;
    launch(8'd3, 8'd5, 8'd7, 1'b1);
    n = 0;
    while (!red_start && n < 20) begin @(negedge clk); n++; end
    d = 0;
    while (!done && d < 20) begin @(negedge clk); d++; end
    check("hsk_tmo_delay", 32'(d), 32'd4);
    wait_done("hsk_tmo");

    // Reducer never drops busy: busy may stay high 64 cycles, the 65th ends it
    mode = 2;
    launch(8'd3, 8'd5, 8'd7, 1'b1);
    n = 0;
    while (!red_busy && n < 20) begin @(negedge clk); n++; end
    d = 0;
    while (!done && d < 200) begin @(negedge clk); d++; end
    check("op_tmo_delay", 32'(d), 32'd65);
    wait_done("op_tmo");
    mode = 0;
    repeat (2) @(negedge clk);

    launch(8'd3, 8'd5, 8'd7, 1'b0);
    check("err_cleared_on_start", 32'(err), 0);
    wait_done("recover");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
